// File: rtl/shift_reg_n_if.sv
// Data/control bundle for the universal shift register.
// The master side drives load/shift controls; the slave side is the register itself.
interface shift_reg_n_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNTW  = 4
);
   logic [WIDTH-1:0] D;
   logic             LOAD;
   logic [1:0]       MODE;
   logic             SIN;
   logic             STEP;
   logic             START;
   logic [CNTW-1:0]  AMOUNT;
   logic [WIDTH-1:0] Q;
   logic             SOUT;
   logic             BUSY;
   logic             DONE;

   modport master (
      output D, LOAD, MODE, SIN, STEP, START, AMOUNT,
      input  Q, SOUT, BUSY, DONE
   );

   modport slave (
      input  D, LOAD, MODE, SIN, STEP, START, AMOUNT,
      output Q, SOUT, BUSY, DONE
   );
endinterface

// File: rtl/shift_reg_n.sv
// WIDTH-bit universal shift register: parallel load, single-step shift/rotate,
// and a counted multi-step engine reporting BUSY and a one-cycle DONE.
module shift_reg_n #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNTW  = 4
) (
   input  logic          CLK,
   input  logic          RST,
   shift_reg_n_if.slave  bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] qReg;
   logic             soutReg;
   logic             busyReg;
   logic             doneReg;
   logic [CNTW-1:0]  count;
   logic [1:0]       latchedMode;

   // One shift/rotate step; result is {bit shifted out, new register value}.
   function automatic logic [WIDTH:0] stepOnce(input logic [1:0] m,
                                               input logic [WIDTH-1:0] v,
                                               input logic s);
      logic [WIDTH:0] r;
      case (m)
         2'b00:   r = {v[WIDTH-1], v[WIDTH-2:0], s};
         2'b01:   r = {v[0], s, v[WIDTH-1:1]};
         2'b10:   r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
         default: r = {v[0], v[0], v[WIDTH-1:1]};
      endcase
      return r;
   endfunction

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         qReg        <= '0;
         soutReg     <= 1'b0;
         busyReg     <= 1'b0;
         doneReg     <= 1'b0;
         count       <= '0;
         latchedMode <= 2'b00;
      end else begin
         doneReg <= 1'b0;
         if (bus.LOAD) begin
            // A load always wins and silently aborts any counted operation.
            qReg    <= bus.D;
            state   <= IDLE;
            busyReg <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.START) begin
                     latchedMode <= bus.MODE;
                     count       <= bus.AMOUNT;
                     if (bus.AMOUNT != '0) begin
                        state   <= RUN;
                        busyReg <= 1'b1;
                     end else begin
                        doneReg <= 1'b1;
                     end
                  end else if (bus.STEP) begin
                     {soutReg, qReg} <= stepOnce(bus.MODE, qReg, bus.SIN);
                  end
               end
               RUN: begin
                  {soutReg, qReg} <= stepOnce(latchedMode, qReg, bus.SIN);
                  count           <= count - CNTW'(1);
                  if (count == CNTW'(1)) begin
                     state   <= IDLE;
                     busyReg <= 1'b0;
                     doneReg <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.Q    = qReg;
   assign bus.SOUT = soutReg;
   assign bus.BUSY = busyReg;
   assign bus.DONE = doneReg;

endmodule

// File: tb/tb_shift_reg_n.sv
// Scoreboard bench for shift_reg_n: counted operations queue their expected
// completion state, and a monitor checks it whenever DONE is presented.
module tb_shift_reg_n;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNTW  = 4;

   typedef struct {
      logic [WIDTH-1:0] q;
      logic             sout;
      int               busyLen;
      string            name;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   busyLen = 0;
   exp_t expQ[$];

   shift_reg_n_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

   shift_reg_n #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
      end
   endtask

   // Monitor: every DONE pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && bus.DONE === 1'b1) begin
         exp_t e;
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got DONE=1 expected DONE=0 (Q=0x%0h)", bus.Q);
         end else begin
            e = expQ.pop_front();
            check({e.name, "_q"}, 32'(bus.Q), 32'(e.q));
            check({e.name, "_sout"}, 32'(bus.SOUT), 32'(e.sout));
            check({e.name, "_busylen"}, 32'(busyLen), 32'(e.busyLen));
            check({e.name, "_busy_at_done"}, 32'(bus.BUSY), 32'd0);
         end
         busyLen = 0;
      end else if (bus.BUSY === 1'b1) begin
         busyLen++;
      end else begin
         busyLen = 0;
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      bus.LOAD  = 1'b0;
      bus.START = 1'b0;
      bus.STEP  = 1'b0;
   endtask

   task automatic load(input logic [WIDTH-1:0] d);
      bus.D    = d;
      bus.LOAD = 1'b1;
      cyc();
      bus.LOAD = 1'b0;
   endtask

   task automatic start(input logic [1:0] m, input logic [CNTW-1:0] amt, input logic s,
                        input logic [WIDTH-1:0] q, input logic so, input string name);
      exp_t e;
      e.q = q; e.sout = so; e.busyLen = int'(amt); e.name = name;
      expQ.push_back(e);
      bus.MODE   = m;
      bus.AMOUNT = amt;
      bus.SIN    = s;
      bus.START  = 1'b1;
      cyc();
      bus.START  = 1'b0;
   endtask

   task automatic waitDone(input string name);
      for (int i = 0; i < 40; i++) begin
         #1;
         if (expQ.size() == 0) return;
         @(negedge clk);
      end
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0 pending", name, expQ.size());
      expQ.delete();
   endtask

   initial begin
      // Reset with garbage on the inputs
      rst        = 1'b1;
      bus.D      = 8'hFF;
      bus.LOAD   = 1'b1;
      bus.MODE   = 2'b10;
      bus.SIN    = 1'b1;
      bus.STEP   = 1'b1;
      bus.START  = 1'b1;
      bus.AMOUNT = 4'd3;
      cyc();
      cyc();
      rst = 1'b0;
      idle();
      check("reset_q", 32'(bus.Q), 32'h00);
      check("reset_sout", 32'(bus.SOUT), 32'd0);
      check("reset_busy", 32'(bus.BUSY), 32'd0);
      check("reset_done", 32'(bus.DONE), 32'd0);

      // Counted shift toward MSB
      load(8'h96);
      check("load_q", 32'(bus.Q), 32'h96);
      start(2'b00, 4'd3, 1'b0, 8'hB0, 1'b0, "shl3");
      check("shl3_busy", 32'(bus.BUSY), 32'd1);
      waitDone("shl3");

      // Counted rotate right, then back-to-back rotate left by WIDTH
      load(8'h96);
      start(2'b11, 4'd3, 1'b0, 8'hD2, 1'b1, "rotr3");
      waitDone("rotr3");
      start(2'b10, 4'd8, 1'b0, 8'hD2, 1'b0, "rotl8");
      waitDone("rotl8");

      // Serial right shift with single steps
      load(8'h96);
      bus.MODE = 2'b01;
      bus.SIN  = 1'b1;
      bus.STEP = 1'b1;
      cyc();
      check("step1_q", 32'(bus.Q), 32'hCB);
      check("step1_sout", 32'(bus.SOUT), 32'd0);
      cyc();
      bus.STEP = 1'b0;
      check("step2_q", 32'(bus.Q), 32'hE5);
      check("step2_sout", 32'(bus.SOUT), 32'd1);
      check("step2_busy", 32'(bus.BUSY), 32'd0);
      check("step2_done", 32'(bus.DONE), 32'd0);

      // Abort: START/STEP ignored while running, LOAD aborts without DONE
      load(8'h01);
      bus.MODE   = 2'b00;
      bus.AMOUNT = 4'd5;
      bus.SIN    = 1'b0;
      bus.START  = 1'b1;
      cyc();
      bus.START = 1'b0;
      cyc();
      cyc();
      check("abort_mid_q", 32'(bus.Q), 32'h04);
      bus.MODE   = 2'b11;
      bus.AMOUNT = 4'd1;
      bus.START  = 1'b1;
      bus.STEP   = 1'b1;
      cyc();
      idle();
      check("ignore_q", 32'(bus.Q), 32'h08);
      check("ignore_busy", 32'(bus.BUSY), 32'd1);
      load(8'h5A);
      check("abort_q", 32'(bus.Q), 32'h5A);
      check("abort_busy", 32'(bus.BUSY), 32'd0);
      repeat (4) cyc();
      check("abort_hold_q", 32'(bus.Q), 32'h5A);

      // AMOUNT=0: immediate DONE, no BUSY, Q unchanged
      start(2'b00, 4'd0, 1'b1, 8'h5A, 1'b0, "amt0");
      waitDone("amt0");
      cyc();
      check("amt0_after_done", 32'(bus.DONE), 32'd0);

      // AMOUNT > WIDTH on a shift flushes with SIN
      load(8'hA5);
      start(2'b01, 4'd10, 1'b1, 8'hFF, 1'b1, "flush10");
      waitDone("flush10");

      // Reset during a run: reset values, no DONE afterwards
      load(8'hFF);
      bus.MODE   = 2'b00;
      bus.AMOUNT = 4'd4;
      bus.SIN    = 1'b1;
      bus.START  = 1'b1;
      cyc();
      bus.START = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("rstrun_q", 32'(bus.Q), 32'h00);
      check("rstrun_sout", 32'(bus.SOUT), 32'd0);
      check("rstrun_busy", 32'(bus.BUSY), 32'd0);
      check("rstrun_done", 32'(bus.DONE), 32'd0);
      repeat (6) cyc();
      check("rstrun_hold_q", 32'(bus.Q), 32'h00);
      check("queue_drained", 32'(expQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/shift_reg_n.md
# shift_reg_n

Parametrised universal shift register. Generalises the fixed 4-bit load/shift register to WIDTH bits and adds:
- four shift/rotate modes with serial in/out;
- single-step shifts;
- a counted multi-step shift engine with a BUSY/DONE handshake.

It sits between the parallel data path and bit-serial I/O logic. It also serves as a barrel-shift substitute where multi-cycle latency is acceptable.

## Interface
Parameters:
- WIDTH, 8, register width in bits (≥2)
- CNTW, 4, width of AMOUNT and the internal step counter (≥1)

Ports (one clock domain; reset is synchronous and active-high):
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  synchronous active-high reset
- D  input  WIDTH  parallel load data
- LOAD  input  1  parallel load strobe
- MODE  input  2  00 shift toward MSB, 01 shift toward LSB, 10 rotate toward MSB, 11 rotate toward LSB
- SIN  input  1  serial input for modes 00/01; ignored for rotates
- STEP  input  1  single shift/rotate when idle
- START  input  1  begin counted operation when idle
- AMOUNT  input  CNTW  number of steps for START (0..2^CNTW-1)
- Q  output  WIDTH  register contents
- SOUT  output  1  last bit shifted or rotated out (registered)
- BUSY  output  1  counted operation in progress
- DONE  output  1  one-cycle pulse on counted-operation completion

## Operation
- Reset values: Q=0, SOUT=0, BUSY=0, DONE=0; counter=0; latched mode=00; FSM=IDLE.
- Priority on any edge: RST > LOAD > (START | STEP) > RUN stepping.
- One step per mode:
  - 00: Q←{Q[W-2:0],SIN}, SOUT←Q[W-1]
  - 01: Q←{SIN,Q[W-1:1]}, SOUT←Q[0]
  - 10: Q←{Q[W-2:0],Q[W-1]}, SOUT←Q[W-1]
  - 11: Q←{Q[0],Q[W-1:1]}, SOUT←Q[0]
- LOAD: Q←D; SOUT unchanged. If it occurs in RUN, the operation is aborted: FSM→IDLE, BUSY→0, no DONE.
- FSM states: IDLE, RUN.
- IDLE:
  - STEP=1 (and START=0): one step using live MODE and SIN. No BUSY, no DONE.
  - START=1: latch MODE into the latched mode and AMOUNT into the counter.
    - AMOUNT≠0: →RUN, BUSY←1.
    - AMOUNT=0: stay in IDLE, DONE←1 next cycle, Q unchanged.
  - START and STEP together: START wins; STEP is dropped.
- RUN:
  - Each cycle: one step using the latched mode and live SIN; counter decrements.
  - On the step where the counter reaches 0: →IDLE, BUSY←0, DONE←1.
  - START and STEP are ignored; MODE changes have no effect.
- DONE is high for exactly one cycle and is otherwise 0.
- AMOUNT ≥ WIDTH is legal:
  - shift modes flush the register entirely with SIN;
  - rotate by a multiple of WIDTH restores the original Q.

## Timing
- LOAD/STEP: Q and SOUT update at the sampling edge; 1-cycle latency.
- START with AMOUNT=N>0 sampled at edge k:
  - BUSY=1 from after edge k;
  - steps occur at edges k+1..k+N;
  - after edge k+N: BUSY=0, DONE=1; DONE clears after edge k+N+1.
- START accepted at edge k+N+1 (DONE cycle) → new operation. Back-to-back throughput is N+1 cycles per operation.
- START with AMOUNT=0 at edge k: DONE=1 after edge k, for one cycle.
- SIN is sampled at each stepping edge, not latched at START.
- RST mid-RUN: all outputs return to reset values next cycle; no DONE.

## Test plan
- Reset: run RST=1 for 2 cycles with arbitrary inputs → Q=0x00, SOUT=0, BUSY=0, DONE=0.
- Counted shift, WIDTH=8:
  - LOAD D=0x96, then START AMOUNT=3 MODE=00 SIN=0.
  - → BUSY high for 3 cycles, then Q=0xB0, SOUT=0, DONE high for 1 cycle.
- Counted rotate:
  - LOAD 0x96, START AMOUNT=3 MODE=11 → Q=0xD2, SOUT=1.
  - Then START AMOUNT=8 MODE=10 → Q=0xD2 unchanged.
  - DONE pulses exactly once per operation.
- Serial right shift with STEP:
  - LOAD 0x96, STEP twice with MODE=01 SIN=1 → Q=0xCB then 0xE5; SOUT=0 then 1.
  - BUSY and DONE stay 0.
- Abort and ignore:
  - START AMOUNT=5 MODE=00 from Q=0x01.
  - After 2 steps (Q=0x04), assert START and STEP → both ignored.
  - Next cycle LOAD D=0x5A → Q=0x5A, BUSY=0, no DONE.
- Edge cases:
  - START AMOUNT=0 → Q unchanged, DONE 1 cycle, BUSY never high.
  - RST at the second cycle of an AMOUNT=4 run → reset values, no DONE.
